// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator sequencer.
// The divide path is enabled by defining ACC_SEQ_DIV_EN.
package acc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        SUB   = 3'd4,
        FINAL = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic ACC_IN_ALU = 1'b0;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Control/status bundle between the sequencer (master) and the accumulator/ALU side (slave).
// The divide-related signals only carry activity when ACC_SEQ_DIV_EN is defined.
interface acc_seq_ctrl_if #(parameter int N = 4);

    logic         start;
    logic         op_div;
    logic [N-1:0] b_data;
    logic [N-1:0] acc_high_data;
    logic [N-1:0] acc_low_data;
    logic         alu_carry;
    logic         alu_sub;
    logic         acc_high_reset_p;
    logic         acc_in_select;
    logic [1:0]   acc_high_select;
    logic [1:0]   acc_low_select;
    logic         fill_value;
    logic         busy;
    logic         done;
    logic         div_zero;

    modport master (
        input  start, op_div, b_data, acc_high_data, acc_low_data, alu_carry,
        output alu_sub, acc_high_reset_p, acc_in_select, acc_high_select,
               acc_low_select, fill_value, busy, done, div_zero
    );

    modport slave (
        output start, op_div, b_data, acc_high_data, acc_low_data, alu_carry,
        input  alu_sub, acc_high_reset_p, acc_in_select, acc_high_select,
               acc_low_select, fill_value, busy, done, div_zero
    );

endinterface

// File: rtl/acc_seq_ctrl.sv
// Shift-and-add multiply / restoring divide sequencer for the accumulator + ALU pair.
// Divide path, FINAL state and div_zero exist only when ACC_SEQ_DIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | clear accumulator high half, reset counter and flags
// ADD   | multiply: load high with high+b when multiplier LSB is set
// SHIFT | shift right (multiply) or left (divide), count one iteration
// SUB   | divide: load high with high-b when no borrow, record quotient bit
// FINAL | divide: last left shift of low half, pushes out the dummy bit
// DONE  | one-cycle completion pulse
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    acc_seq_ctrl_if.master  bus
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N);
    localparam logic [CW-1:0] CNT_PRE  = CW'(N - 1);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_CLEAR = CLEAR;
    localparam logic [2:0] ST_ADD   = ADD;
    localparam logic [2:0] ST_SHIFT = SHIFT;
    localparam logic [2:0] ST_SUB   = SUB;
    localparam logic [2:0] ST_FINAL = FINAL;
    localparam logic [2:0] ST_DONE  = DONE;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          qbit_q, qbit_d;
    logic          op_div_q, op_div_d;

    logic          alu_sub_c, high_reset_c, fill_c, busy_c, done_c;
    logic [1:0]    high_sel_c, low_sel_c;

`ifdef ACC_SEQ_DIV_EN
    logic          div_zero_q, div_zero_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        qbit_d       = qbit_q;
        op_div_d     = op_div_q;
`ifdef ACC_SEQ_DIV_EN
        div_zero_d   = div_zero_q;
`endif
        alu_sub_c    = ALU_ADD;
        high_reset_c = 1'b0;
        fill_c       = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        high_sel_c   = SEL_HOLD;
        low_sel_c    = SEL_HOLD;

        case (state_q)
            ST_IDLE: begin
`ifdef ACC_SEQ_DIV_EN
                if (bus.start) begin
                    div_zero_d = 1'b0;
                    op_div_d   = bus.op_div;
                    // A zero divisor finishes immediately and leaves the accumulator alone
                    if (bus.op_div && (bus.b_data == '0)) begin
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d    = ST_CLEAR;
                    end
                end
`else
                if (bus.start && !bus.op_div) begin
                    op_div_d = 1'b0;
                    state_d  = ST_CLEAR;
                end
`endif
            end
            ST_CLEAR: begin
                busy_c       = 1'b1;
                high_reset_c = 1'b1;
                carry_d      = 1'b0;
                qbit_d       = 1'b0;
                cnt_d        = '0;
                state_d      = op_div_q ? ST_SHIFT : ST_ADD;
            end
            ST_ADD: begin
                busy_c = 1'b1;
                if (bus.acc_low_data[0]) begin
                    high_sel_c = SEL_LOAD;
                    carry_d    = bus.alu_carry;
                end else begin
                    carry_d    = 1'b0;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy_c = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (op_div_q) begin
                    high_sel_c = SEL_SHL;
                    low_sel_c  = SEL_SHL;
                    fill_c     = qbit_q;
                    state_d    = ST_SUB;
                end else begin
                    high_sel_c = SEL_SHR;
                    low_sel_c  = SEL_SHR;
                    fill_c     = carry_q;
                    state_d    = (cnt_q == CNT_PRE) ? ST_DONE : ST_ADD;
                end
            end
`ifdef ACC_SEQ_DIV_EN
            ST_SUB: begin
                busy_c    = 1'b1;
                alu_sub_c = ALU_SUB;
                if (bus.alu_carry) begin
                    high_sel_c = SEL_LOAD;
                    qbit_d     = 1'b1;
                end else begin
                    qbit_d     = 1'b0;
                end
                state_d = (cnt_q == CNT_LAST) ? ST_FINAL : ST_SHIFT;
            end
            ST_FINAL: begin
                busy_c    = 1'b1;
                low_sel_c = SEL_SHL;
                fill_c    = qbit_q;
                state_d   = ST_DONE;
            end
`endif
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            qbit_q   <= 1'b0;
            op_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            qbit_q   <= qbit_d;
            op_div_q <= op_div_d;
        end
    end

`ifdef ACC_SEQ_DIV_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_zero_q <= 1'b0;
        else          div_zero_q <= div_zero_d;
    end
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

    assign bus.alu_sub          = alu_sub_c;
    assign bus.acc_high_reset_p = high_reset_c;
    assign bus.acc_in_select    = ACC_IN_ALU;
    assign bus.acc_high_select  = high_sel_c;
    assign bus.acc_low_select   = low_sel_c;
    assign bus.fill_value       = fill_c;
    assign bus.busy             = busy_c;
    assign bus.done             = done_c;

endmodule
